// File: rtl/xbus_dispatch.sv
// xbus_dispatch
// Row-bus dispatcher feeding the row-bus/PE array. Tagged operands from the
// global buffer are queued in a small FIFO. Each entry is multicast onto the
// row buses selected by its row mask. It is held until every targeted row
// has accepted it, and only then is it counted as issued.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush / busy      drop all buffered and in-flight data / flush in progress
//   in_valid/in_ready upstream handshake; in_data, in_row_mask, in_col_id
//   bus_valid/ready   per-row handshake; bus_data and bus_col_id shared by rows
//   fifo_level        entries waiting in the FIFO (not the one on the bus)
//   issue_cnt         fully dispatched entries, wraps modulo 2^32
//   err_mask          sticky: an entry with an all-zero row mask was seen
module xbus_dispatch #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_ROW    = 4,
  parameter int DEPTH      = 4,
  localparam int CIW       = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [NUM_ROW-1:0]    in_row_mask,
  input  logic [CIW-1:0]        in_col_id,
  output logic [NUM_ROW-1:0]    bus_valid,
  input  logic [NUM_ROW-1:0]    bus_ready,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic [CIW-1:0]        bus_col_id,
  output logic [LW-1:0]         fifo_level,
  output logic [31:0]           issue_cnt,
  output logic                  err_mask
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_FLUSH} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_ROW-1:0]    mask;
    logic [CIW-1:0]        col;
  } entry_t;

  entry_t                r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  state_t                r_state;
  logic [NUM_ROW-1:0]    r_pending;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CIW-1:0]        r_col;
  logic [31:0]           r_issue_cnt;
  logic                  r_err_mask;
  logic                  r_busy;

  entry_t                w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_done;
  logic [NUM_ROW-1:0]    w_remain;

  // in_ready looks only at registered state plus flush/rst, never at
  // bus_ready, so there is no combinational path from the row buses upstream.
  assign in_ready = !rst && (r_level < LW'(DEPTH)) && (r_state != ST_FLUSH) && !flush;
  assign w_push   = in_valid && in_ready;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_remain = r_pending & ~bus_ready;
  // In IDLE pending is already zero, so w_done is trivially true there.
  assign w_done   = (w_remain == '0);
  assign w_pop    = !flush && (r_level != '0) &&
                    ((r_state == ST_IDLE) || ((r_state == ST_DISPATCH) && w_done));

  // NOTE: FIFO storage has no reset; validity is tracked entirely by the
  // pointers and level, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{data: in_data, mask: in_row_mask, col: in_col_id};
  end

  // NOTE: all state updates below are non-blocking, so every branch reads the
  // pre-edge values of r_pending, r_level and r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pending   <= '0;
      r_data      <= '0;
      r_col       <= '0;
      r_issue_cnt <= '0;
      r_err_mask  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (flush) begin
      // Flush beats push (in_ready is low) and beats completion (no count).
      r_state   <= ST_FLUSH;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_pending <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_busy <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            if (w_head.mask == '0) begin
              r_err_mask <= 1'b1;
            end else begin
              r_data    <= w_head.data;
              r_col     <= w_head.col;
              r_pending <= w_head.mask;
              r_state   <= ST_DISPATCH;
            end
          end
        end
        ST_DISPATCH: begin
          r_pending <= w_remain;
          if (w_done) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
            if (w_pop && (w_head.mask != '0)) begin
              // Back-to-back: next head replaces the completed entry.
              r_data    <= w_head.data;
              r_col     <= w_head.col;
              r_pending <= w_head.mask;
            end else begin
              // A zero-mask head is discarded here; it used this pop slot.
              if (w_pop) r_err_mask <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign bus_valid  = r_pending;
  assign bus_data   = r_data;
  assign bus_col_id = r_col;
  assign fifo_level = r_level;
  assign issue_cnt  = r_issue_cnt;
  assign err_mask   = r_err_mask;

endmodule
